// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds,
// a read-valid strobe, sticky overflow/underflow flags and a synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        clr_err,
  input  logic                        wr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        rd,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  output logic [$clog2(DEPTH):0]      fifo_cnt,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_empty,
  output logic                        almost_full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign empty        = (fifo_cnt == '0);
  assign full         = (fifo_cnt == CW'(DEPTH));
  assign almost_empty = (fifo_cnt <= CW'(AEMPTY_TH));
  assign almost_full  = (fifo_cnt >= CW'(AFULL_TH));

  // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
  assign rd_acc = rd && !empty;
  assign wr_acc = wr && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      rd_valid  <= 1'b0;
      overflow  <= overflow  && !clr_err;
      underflow <= underflow && !clr_err;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      rd_valid <= rd_acc;
      case ({wr_acc, rd_acc})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow  <= (overflow  && !clr_err) || (wr && !wr_acc);
      underflow <= (underflow && !clr_err) || (rd && !rd_acc);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, flush, clr_err, wr, rd;
  logic [7:0] data_in, data_out;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0] fifo_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_rv, m_ov, m_un;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_cnt(fifo_cnt),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model at the edge, return 1 ns after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c, input logic rs);
    logic rda, wra;
    wr = w; data_in = d; rd = r; flush = f; clr_err = c; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_dout = 8'h00; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    end else if (f) begin
      q.delete(); m_rv = 1'b0;
      m_ov = m_ov && !c; m_un = m_un && !c;
    end else begin
      rda = r && (q.size() > 0);
      wra = w && ((q.size() < 8) || rda);
      m_ov = (m_ov && !c) || (w && !wra);
      m_un = (m_un && !c) || (r && !rda);
      m_rv = rda;
      if (rda) m_dout = q.pop_front();
      if (wra) q.push_back(d);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    total++;
    if ({fifo_cnt, empty, full, almost_empty, almost_full, rd_valid, overflow, underflow} !==
        {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b af=%b rv=%b ov=%b un=%b, want cnt=0 e=1 f=0 ae=1 af=0 rv=0 ov=0 un=0",
               fifo_cnt, empty, full, almost_empty, almost_full, rd_valid, overflow, underflow);
      bad++;
    end
    total++;
    if (data_out !== 8'h00) begin
      $display("FAIL reset_data: got %h want 00", data_out); bad++;
    end
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 8) begin
        total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          $display("FAIL fill_full8: full=%b ov=%b want full=1 ov=0", full, overflow); bad++;
        end
      end
    end
    total++;
    if (fifo_cnt !== 4'd8 || overflow !== 1'b1 || full !== 1'b1) begin
      $display("FAIL fill_overflow: cnt=%0d ov=%b full=%b want 8 1 1", fifo_cnt, overflow, full); bad++;
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (k <= 8 && (data_out !== 8'(k) || rd_valid !== 1'b1)) begin
        $display("FAIL drain_data%0d: got %h rv=%b want %h rv=1", k, data_out, rd_valid, 8'(k)); bad++;
      end else if (k > 8 && (data_out !== 8'h08 || rd_valid !== 1'b0)) begin
        $display("FAIL drain_hold%0d: got %h rv=%b want 08 rv=0", k, data_out, rd_valid); bad++;
      end
    end
    total++;
    if (underflow !== 1'b1 || empty !== 1'b1 || fifo_cnt !== 4'd0) begin
      $display("FAIL drain_underflow: un=%b empty=%b cnt=%0d want 1 1 0", underflow, empty, fifo_cnt); bad++;
    end
  endtask

  task automatic test_thresholds();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (fifo_cnt !== 4'(k) || almost_empty !== (k <= 2) || almost_full !== (k >= 6)) begin
        $display("FAIL thr_up%0d: cnt=%0d ae=%b af=%b want cnt=%0d ae=%b af=%b",
                 k, fifo_cnt, almost_empty, almost_full, k, (k <= 2), (k >= 6)); bad++;
      end
    end
    for (int k = 5; k >= 2; k--) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (fifo_cnt !== 4'(k) || almost_empty !== (k <= 2) || almost_full !== (k >= 6)) begin
        $display("FAIL thr_dn%0d: cnt=%0d ae=%b af=%b want cnt=%0d ae=%b af=%b",
                 k, fifo_cnt, almost_empty, almost_full, k, (k <= 2), (k >= 6)); bad++;
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_cnt !== 4'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin
      $display("FAIL simul_empty: cnt=%0d un=%b rv=%b want 1 1 0", fifo_cnt, underflow, rd_valid); bad++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin
      $display("FAIL simul_empty_read: got %h rv=%b want a5 rv=1", data_out, rd_valid); bad++;
    end
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_cnt !== 4'd8 || data_out !== 8'h10 || rd_valid !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL simul_full: cnt=%0d data=%h rv=%b ov=%b want 8 10 1 0",
               fifo_cnt, data_out, rd_valid, overflow); bad++;
    end
    for (int k = 1; k < 8; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (data_out !== 8'h77) begin
      $display("FAIL simul_full_tail: got %h want 77", data_out); bad++;
    end
  endtask

  task automatic test_pointer_wrap();
    int errs = 0;
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 8'(k + 3), 1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (data_out !== 8'(k) || rd_valid !== 1'b1 || fifo_cnt !== 4'd3) begin
        $display("FAIL wrap%0d: data=%h rv=%b cnt=%0d want %h 1 3", k, data_out, rd_valid, fifo_cnt, 8'(k));
        bad++;
      end
    end
  endtask

  task automatic test_flush_clr();
    do_reset();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (fifo_cnt !== 4'd5 || overflow !== 1'b1 || underflow !== 1'b1) begin
      $display("FAIL flush_setup: cnt=%0d ov=%b un=%b want 5 1 1", fifo_cnt, overflow, underflow); bad++;
    end
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (fifo_cnt !== 4'd0 || overflow !== 1'b1 || underflow !== 1'b1 || rd_valid !== 1'b0 ||
        data_out !== 8'h22) begin
      $display("FAIL flush: cnt=%0d ov=%b un=%b rv=%b data=%h want 0 1 1 0 22",
               fifo_cnt, overflow, underflow, rd_valid, data_out); bad++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL clr_err: ov=%b un=%b want 0 0", overflow, underflow); bad++;
    end
    for (int k = 0; k < 8; k++) step(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (overflow !== 1'b1 || fifo_cnt !== 4'd8) begin
      $display("FAIL clr_vs_set: ov=%b cnt=%0d want 1 8", overflow, fifo_cnt); bad++;
    end
  endtask

  task automatic test_random();
    logic w, r, f, c, rs;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      w  = ($urandom_range(99) < 55);
      r  = ($urandom_range(99) < 45);
      f  = ($urandom_range(99) < 3);
      c  = ($urandom_range(99) < 5);
      rs = ($urandom_range(199) == 0);
      step(w, 8'($urandom), r, f, c, rs);
      total++;
      if (fifo_cnt !== 4'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 8) ||
          almost_empty !== (q.size() <= 2) || almost_full !== (q.size() >= 6) ||
          rd_valid !== m_rv || data_out !== m_dout || overflow !== m_ov || underflow !== m_un) begin
        $display("FAIL random%0d: cnt=%0d data=%h rv=%b ov=%b un=%b e=%b f=%b ae=%b af=%b want cnt=%0d data=%h rv=%b ov=%b un=%b",
                 n, fifo_cnt, data_out, rd_valid, overflow, underflow, empty, full, almost_empty,
                 almost_full, q.size(), m_dout, m_rv, m_ov, m_un);
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_err = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
    m_dout = 8'h00; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_wrap();
    test_thresholds();
    test_simultaneous();
    test_pointer_wrap();
    test_flush_clr();
    test_random();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO that succeeds the fixed 8x8 FIFO. It is generalised in data width and depth, and adds programmable almost-full/almost-empty thresholds, a read-valid strobe, sticky overflow/underflow error flags and a synchronous flush. It sits between a single-clock producer and consumer and serves as the standard buffering element for the UVM FIFO environment.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when fifo_cnt ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when fifo_cnt ≤ AEMPTY_TH (0..DEPTH-1)
- CW (derived, localparam) = $clog2(DEPTH)+1; PW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous flush of contents (does not clear error flags)
- clr_err  in  1  clears the overflow/underflow sticky flags
- wr  in  1  write request
- data_in  in  DATA_W  write data
- rd  in  1  read request
- data_out  out  DATA_W  registered read data
- rd_valid  out  1  data_out updated by the read accepted in the previous cycle
- fifo_cnt  out  CW  current occupancy, 0..DEPTH
- empty / full  out  1  fifo_cnt==0 / fifo_cnt==DEPTH (combinational from fifo_cnt)
- almost_empty / almost_full  out  1  threshold compares on fifo_cnt (combinational)
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH x DATA_W register array; wr_ptr and rd_ptr are PW bits and wrap naturally from DEPTH-1 to 0. Memory has no reset.
- rd_acc = rd && !empty. wr_acc = wr && (!full || rd_acc). The write depends on the read; the read never depends on the write, so there is no combinational loop.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments.
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr increments; rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds its value.
- fifo_cnt: +1 for wr_acc only, -1 for rd_acc only, unchanged for both or neither. It never exceeds DEPTH and never goes below 0.
- Simultaneous wr and rd:
  - When empty: the write is accepted, the read is ignored, underflow is set, fifo_cnt goes 0→1.
  - When full: both are accepted and fifo_cnt stays at DEPTH.
  - This deliberately differs from the predecessor, which advanced rd_ptr on an empty read.
- overflow sets on wr && !wr_acc. underflow sets on rd && !rd_acc.
  - Both remain set until rst or clr_err.
  - If clr_err coincides with a new error event, the set wins.
- flush: pointers and fifo_cnt go to 0 and rd_valid goes to 0. data_out holds.
  - Any wr/rd in the flush cycle is dropped.
  - No error flag is set by a dropped request in that cycle.
- Priority order: rst > flush > normal operation.

## Timing
- Reset values (cycle after rst sampled high): fifo_cnt=0, empty=1, full=0, almost_empty=1, almost_full=0 (when AFULL_TH>0), data_out=0, rd_valid=0, overflow=0, underflow=0, wr_ptr=rd_ptr=0.
- A reset asserted mid-burst discards all contents in one cycle. Any wr/rd in that cycle is ignored.
- Write-to-read latency:
  - Data written at edge N is readable by a rd at edge N+1.
  - It appears on data_out after edge N+1, with rd_valid high for that cycle.
- Read latency: 1 cycle from rd sampled to data_out/rd_valid.
- Status flags (empty, full, almost_*) update in the same cycle as fifo_cnt, i.e. one edge after the accepted request.
- Back-to-back rd every cycle drains one word per cycle. rd_valid stays high continuously until the cycle after the read that empties the FIFO.

## Test plan
- Reset: drive rst=1 for 2 cycles with wr=rd=1 → all outputs at their reset values, fifo_cnt=0, no error flags.
- Fill/wrap (DATA_W=8, DEPTH=8):
  - Write 0x01..0x0A on consecutive cycles → full=1 after the 8th write; writes 9 and 10 set overflow=1; fifo_cnt=8.
  - Then read 10 times → data_out sequence 0x01..0x08 with rd_valid high; underflow=1; empty=1.
- Thresholds (AFULL_TH=6, AEMPTY_TH=2): write 6 words → almost_empty drops when fifo_cnt=3 and almost_full rises when fifo_cnt=6; read 4 words → almost_full drops at 5 and almost_empty rises at 2.
- Simultaneous wr+rd:
  - When empty: wr=rd=1 with data_in=0xA5 → fifo_cnt=1, underflow=1, rd_valid=0; the next read returns 0xA5.
  - When full: wr=rd=1 → fifo_cnt stays 8, the oldest word appears on data_out, no overflow.
- Pointer wrap: 20 cycles of continuous wr+rd at occupancy 3 with incrementing data → output stream is in order, lagging the input by 3 words; fifo_cnt stays 3.
- flush/clr_err:
  - With 5 words stored and both error flags set, pulse flush with wr=1 → fifo_cnt=0 and the error flags stay set.
  - Then pulse clr_err → overflow=underflow=0.
  - clr_err together with a write while full → overflow stays 1.
